// File: rtl/buffer_ram_read_streamer_if.sv
// Command, BufferRAM read port and output stream of the read streamer.
// master = command/consumer/RAM side, slave = the streamer itself.
interface buffer_ram_read_streamer_if #(
  parameter int DEPTHAD = 9,
  parameter int WIDTH   = 16
);
  logic               start;
  logic [DEPTHAD-1:0] base;
  logic [DEPTHAD:0]   length;
  logic               abort;
  logic [DEPTHAD-1:0] raddr;
  logic               rd_issue;
  logic [WIDTH-1:0]   rdata;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    output start, base, length, abort, rdata, out_ready,
    input  raddr, rd_issue, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  start, base, length, abort, rdata, out_ready,
    output raddr, rd_issue, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/buffer_ram_read_streamer.sv
// Streams a (base,length) burst out of a fixed-latency BufferRAM; first word READ_LATENCY+1 cycles after start.
// Reads are issued only while FIFO occupancy plus in-flight reads leaves a free slot, so backpressure never drops data.
module buffer_ram_read_streamer #(
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 4,
  parameter int WIDTH        = 16,
  parameter int FIFO_DEPTH   = READ_LATENCY + 1,
  parameter int DEPTHAD      = $clog2(DEPTH)
) (
  input logic                       clk,
  input logic                       rstn,
  buffer_ram_read_streamer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
  localparam logic [DEPTHAD:0]   LEN_ONE  = 1;
  localparam logic [DEPTHAD-1:0] ADDR_ONE = 1;
  localparam logic [PW-1:0]      PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DEPTHAD-1:0]      addr_q, last_addr_q;
  logic [DEPTHAD:0]        issue_rem_q, pop_rem_q;
  logic [READ_LATENCY-1:0] vld_sr_q;
  logic [CW-1:0]           fifo_cnt_q, inflight_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic                    zero_pend_q, done_q;

  logic accept, abort_go, push, pop, fifo_nonempty, credit_ok, issue, done_d;

  // Abort outranks a same-cycle start even when idle.
  assign accept        = bus.start && !bus.abort && (state_q == IDLE);
  assign abort_go      = bus.abort && (state_q != IDLE);
  assign push          = vld_sr_q[READ_LATENCY-1];
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign pop           = fifo_nonempty && bus.out_ready;
  assign credit_ok     = (fifo_cnt_q + inflight_q) < (CW'(FIFO_DEPTH) + CW'(pop));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = zero_pend_q;
    case (state_q)
      IDLE: begin
        if (accept && (bus.length != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        issue = credit_ok;
        if (issue && (issue_rem_q == LEN_ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((pop_rem_q == '0) || ((pop_rem_q == LEN_ONE) && pop)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_go) begin
      state_d = IDLE;
      issue   = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      issue_rem_q <= '0;
      pop_rem_q   <= '0;
      vld_sr_q    <= '0;
      fifo_cnt_q  <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      zero_pend_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      zero_pend_q <= accept && (bus.length == '0);

      if (accept) begin
        addr_q      <= bus.base;
        issue_rem_q <= bus.length;
        pop_rem_q   <= bus.length;
      end
      if (issue) begin
        last_addr_q <= addr_q;
        addr_q      <= (addr_q == DEPTHAD'(DEPTH - 1)) ? '0 : addr_q + ADDR_ONE;
        issue_rem_q <= issue_rem_q - LEN_ONE;
      end
      if (pop) pop_rem_q <= pop_rem_q - LEN_ONE;

      // Valid bits ride alongside the RAM pipeline so the last stage lines up with rdata.
      vld_sr_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_sr_q[i] <= vld_sr_q[i-1];
      inflight_q <= inflight_q + CW'(issue) - CW'(push);

      if (push) begin
        mem_q[wr_ptr_q] <= bus.rdata;
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_ONE;
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);

      if (abort_go) begin
        issue_rem_q <= '0;
        pop_rem_q   <= '0;
        vld_sr_q    <= '0;
        inflight_q  <= '0;
        fifo_cnt_q  <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
      end
    end
  end

  assign bus.raddr     = issue ? addr_q : last_addr_q;
  assign bus.rd_issue  = issue;
  assign bus.out_valid = fifo_nonempty;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_last  = fifo_nonempty && (pop_rem_q == LEN_ONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_buffer_ram_read_streamer.sv
// Bench for buffer_ram_read_streamer: directed bursts, abort/reset cases and randomized bursts
// checked against a queue-based model of the expected word stream.
module tb_buffer_ram_read_streamer;
  localparam int DEPTH = 512;
  localparam int RL    = 4;
  localparam int WIDTH = 16;
  localparam int FD    = RL + 1;
  localparam int AW    = $clog2(DEPTH);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  buffer_ram_read_streamer_if #(.DEPTHAD(AW), .WIDTH(WIDTH)) bus ();

  buffer_ram_read_streamer #(
    .DEPTH(DEPTH), .READ_LATENCY(RL), .WIDTH(WIDTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  // BufferRAM with RL cycles from raddr to rdata.
  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= mem[bus.raddr];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.rdata = pipe[RL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] exp_q[$];
  int exp_len = 0, issued = 0, popped = 0;
  int exp_addr = 0, last_addr = 0;
  int done_cnt = 0, last_cnt = 0, issue_cnt = 0;
  int t0 = 0, first_valid_cyc = -1, done_cyc = -1, last_pop_cyc = -1;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  bit zero_check = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [WIDTH-1:0] w;
    if (bus.rd_issue === 1'b1) begin
      chk("issue_in_burst", 32'(issued < exp_len), 32'd1);
      chk("raddr", 32'(bus.raddr), exp_addr);
      last_addr = exp_addr;
      exp_addr  = (exp_addr + 1) % DEPTH;
      issued++;
      issue_cnt++;
    end else begin
      chk("raddr_hold", 32'(bus.raddr), last_addr);
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(prev_data));
    end
    if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("pop_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(w));
        chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 0));
        popped++;
        last_pop_cyc = cyc;
        if (bus.out_last === 1'b1) last_cnt++;
      end
    end
    chk("credit", 32'((issued - popped) <= FD), 32'd1);
    prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
    prev_data  = bus.out_data;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(bus.busy), 32'd0);
    end
    if (zero_check) begin
      chk("zero_raddr", 32'(bus.raddr), 32'd0);
      chk("zero_rd_issue", 32'(bus.rd_issue), 32'd0);
      chk("zero_out_valid", 32'(bus.out_valid), 32'd0);
      chk("zero_out_data", 32'(bus.out_data), 32'd0);
      chk("zero_out_last", 32'(bus.out_last), 32'd0);
      chk("zero_busy", 32'(bus.busy), 32'd0);
      chk("zero_done", 32'(bus.done), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear(input bit full_reset);
    exp_q.delete();
    exp_len    = 0;
    issued     = 0;
    popped     = 0;
    prev_stall = 1'b0;
    if (full_reset) begin
      last_addr = 0;
      exp_addr  = 0;
    end
  endtask

  task automatic start_burst(input int b, input int l);
    bus.start  = 1'b1;
    bus.base   = AW'(b);
    bus.length = (AW+1)'(l);
    exp_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    exp_len = l;
    issued  = 0;
    popped  = 0;
    exp_addr = b;
    t0 = cyc;
    first_valid_cyc = -1;
    done_cyc = -1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rnd) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.start = (exp_q.size() >= 2) && ($urandom_range(0, 15) == 0);
        bus.base   = AW'($urandom_range(0, DEPTH - 1));
        bus.length = (AW+1)'($urandom_range(1, 30));
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    chk({tag, "_all_popped"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_all_issued"}, issued, exp_len);
  endtask

  initial begin
    int d0, l0, i0, nz, nb;
    bus.start = 1'b0;
    bus.base = '0;
    bus.length = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 100);

    // Reset state
    tick();
    zero_check = 1'b1;
    tick();
    zero_check = 1'b0;
    rstn = 1'b1;
    tick();

    // Basic burst: 110..114, first word at cycle 5, done at cycle 10
    d0 = done_cnt; l0 = last_cnt;
    start_burst(10, 5);
    wait_done("basic", 40, 1'b0);
    chk("basic_first_valid", first_valid_cyc - t0 - 1, 32'd5);
    chk("basic_done_cycle", done_cyc - t0 - 1, 32'd10);
    chk("basic_back_to_back", last_pop_cyc - first_valid_cyc, 32'd4);
    chk("basic_done_count", done_cnt - d0, 32'd1);
    chk("basic_last_count", last_cnt - l0, 32'd1);
    tick();

    // Address wrap 510,511,0,1
    start_burst(510, 4);
    wait_done("wrap", 40, 1'b0);
    chk("wrap_last_addr", last_addr, 32'd1);

    // Backpressure: no consumer for 20 cycles
    bus.out_ready = 1'b0;
    i0 = issue_cnt;
    start_burst(40, 16);
    for (int i = 0; i < 20; i++) tick();
    chk("bp_issue_count", issue_cnt - i0, FD);
    bus.out_ready = 1'b1;
    wait_done("bp", 80, 1'b0);
    chk("bp_popped", popped, 32'd16);

    // Zero-length burst
    d0 = done_cnt;
    start_burst(7, 0);
    wait_done("zero", 10, 1'b0);
    chk("zero_done_cycle", done_cyc - t0 - 1, 32'd1);
    chk("zero_done_count", done_cnt - d0, 32'd1);

    // Abort while idle, and abort+start together, are both no-ops
    d0 = done_cnt;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b1;
    bus.base = AW'(33);
    bus.length = (AW+1)'(3);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_abort_no_done", done_cnt - d0, 32'd0);

    // Abort mid-burst, then a clean short burst
    d0 = done_cnt;
    start_burst(300, 20);
    for (int i = 0; i < 3; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    model_clear(1'b0);
    t0 = cyc - 1;
    tick();
    chk("abort_done_next", done_cyc - t0, 32'd1);
    chk("abort_done_count", done_cnt - d0, 32'd1);
    start_burst(0, 2);
    wait_done("post_abort", 40, 1'b0);
    chk("post_abort_popped", popped, 32'd2);

    // Reset mid-burst
    start_burst(100, 12);
    for (int i = 0; i < 7; i++) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_clear(1'b1);
    zero_check = 1'b1;
    tick();
    zero_check = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    start_burst(200, 3);
    wait_done("post_reset", 40, 1'b0);

    // Randomized bursts with random consumer
    d0 = done_cnt; l0 = last_cnt; nz = 0; nb = 1000;
    for (int b = 0; b < nb; b++) begin
      int len;
      len = $urandom_range(0, 24);
      if (len > 0) nz++;
      bus.out_ready = 1'($urandom_range(0, 1));
      start_burst($urandom_range(0, DEPTH - 1), len);
      wait_done("rand", 4 * len + 40, 1'b1);
    end
    bus.out_ready = 1'b1;
    chk("rand_done_count", done_cnt - d0, nb);
    chk("rand_last_count", last_cnt - l0, nz);

    // Full-depth burst
    start_burst(137, DEPTH);
    wait_done("full", DEPTH + 40, 1'b0);
    chk("full_popped", popped, DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
